move_controller: RTL and testbench
==================================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge system clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: move_valid  input  1  single-cycle move request from the current player.
REQ-004 SHALL have port: position_write  input  16  one-hot target square from the position decoder; bit0 = square 1 … bit8 = square 9; bits 15:9 are invalid squares.
REQ-005 SHALL have port: clear  input  1  synchronous new-game request.
REQ-006 SHALL have port: board_x  output  9  squares marked by player X.
REQ-007 SHALL have port: board_o  output  9  squares marked by player O.
REQ-008 SHALL have port: turn  output  1  player to move; 0 = X, 1 = O.
REQ-009 SHALL have port: illegal_move  output  1  one-cycle pulse when a request is rejected.
REQ-010 SHALL have port: move_done  output  1  one-cycle pulse when a legal move is committed and the game continues.
REQ-011 SHALL have port: winner  output  2  00 none, 01 X, 10 O, 11 draw.
REQ-012 SHALL have port: game_over  output  1  high while the FSM is in DONE.

Function
REQ-013 FSM states SHALL be PLAY, CHECK, WRITE, EVAL, DONE; all outputs registered.
REQ-014 In PLAY, move_valid = 1 SHALL capture position_write into an internal register and go to CHECK; move_valid in any other state SHALL be ignored.
REQ-015 CHECK SHALL reject a move when the captured vector is zero, has any bit 15:9 set, has more than one bit set, or hits a square already set in board_x | board_o.
REQ-016 Rejection SHALL pulse illegal_move for exactly one cycle and return to PLAY with boards and turn unchanged.
REQ-017 Acceptance SHALL go to WRITE, which ORs the captured bits into board_x (turn = 0) or board_o (turn = 1).
REQ-018 EVAL SHALL test the 8 win lines (3 rows, 3 columns, 2 diagonals) for the player who just moved.
REQ-019 On a win, EVAL SHALL set winner to 01 or 10, go to DONE, and leave turn unchanged.
REQ-020 On no win with all 9 squares full, EVAL SHALL set winner = 11 and go to DONE.
REQ-021 Otherwise EVAL SHALL toggle turn, pulse move_done for one cycle, and return to PLAY.
REQ-022 Latency: request sampled at edge E0; illegal_move or board update visible after E1 or E2 respectively; move_done/winner/game_over visible after E3.
REQ-023 DONE SHALL hold the boards, winner and game_over until clear.
REQ-024 clear SHALL take priority in every state: at the next edge, boards = 0, turn = 0, winner = 00, pulses = 0, state = PLAY.
REQ-025 clear and move_valid in the same cycle SHALL result in a cleared board with the move discarded.
REQ-026 A win that completes on the ninth square SHALL report the win, not a draw.

Reset
REQ-027 reset SHALL asynchronously force state = PLAY, board_x = 0, board_o = 0, turn = 0, winner = 00, and illegal_move = move_done = game_over = 0.
REQ-028 reset asserted mid-move (CHECK/WRITE/EVAL) SHALL discard the move with no pulse emitted.

Structure
REQ-029 Shared package ttt_pkg SHALL hold the state enum, the winner codes (NONE/X/O/DRAW) and the 8 nine-bit win-line masks.
REQ-030 Line detection SHALL be one combinational sub-module, win_detector (9-bit board in, win flag out), instantiated once on the moving player's board.

Verification
REQ-031 Legal move: position_write = 16'h0001, turn 0 -> board_x = 9'h001 after E2; move_done pulse after E3; turn = 1.
REQ-032 Occupied square: X plays 16'h0010, then O plays 16'h0010 -> illegal_move one pulse; board_o = 0; turn remains 1.
REQ-033 Invalid input: position_write = 16'h0200, 16'h0000, or 16'h0003 -> illegal_move pulse each time; boards unchanged.
REQ-034 Win: X 0x001, O 0x008, X 0x002, O 0x010, X 0x004 -> winner = 01, game_over = 1; a further move_valid is ignored.
REQ-035 Draw: X 1,2,6,7,9 and O 3,4,5,8 (square numbers) -> winner = 11 after the ninth move.
REQ-036 Async reset asserted in WRITE, and clear asserted in DONE -> all outputs return to their reset values; the next legal move is accepted as X.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: controller states, winner codes and the
// eight three-in-a-row masks. Square n of the board lives in bit n-1.
package ttt_pkg;

  typedef enum logic [2:0] {
    PLAY  = 3'd0,
    CHECK = 3'd1,
    WRITE = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Rows 1-2-3, 4-5-6, 7-8-9; columns 1-4-7, 2-5-8, 3-6-9; diagonals 1-5-9, 3-5-7.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  localparam logic [8:0] FULL_BOARD = 9'h1FF;

endpackage

// File: rtl/move_controller_if.sv
// Bundle of the move request inputs and the board/status outputs.
// The controller connects through the slave modport, the driver of moves
// (position decoder / bench) through the master modport.
interface move_controller_if;

  logic        move_valid;
  logic [15:0] position_write;
  logic        clear;
  logic [8:0]  board_x;
  logic [8:0]  board_o;
  logic        turn;
  logic        illegal_move;
  logic        move_done;
  logic [1:0]  winner;
  logic        game_over;

  modport master (
    output move_valid, position_write, clear,
    input  board_x, board_o, turn, illegal_move, move_done, winner, game_over
  );

  modport slave (
    input  move_valid, position_write, clear,
    output board_x, board_o, turn, illegal_move, move_done, winner, game_over
  );

endinterface

// File: rtl/win_detector.sv
// Purely combinational three-in-a-row detector for one player's board.
module win_detector
  import ttt_pkg::*;
(
  input  logic [8:0] i_board,
  output logic       o_win
);

  // Flag a win as soon as any of the eight line masks is fully covered.
  always_comb begin
    o_win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((i_board & WIN_LINES[i]) == WIN_LINES[i]) begin
        o_win = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_controller.sv
// Tic-tac-toe move controller. A request is captured in PLAY, validated in
// CHECK, committed in WRITE and scored in EVAL; DONE holds the final board
// until a new game is requested with clear.
module move_controller
  import ttt_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  move_controller_if.slave   bus
);

  state_t      r_state;
  logic [15:0] r_captured;
  logic [8:0]  r_boardX;
  logic [8:0]  r_boardO;
  logic        r_turn;
  logic        r_illegalMove;
  logic        r_moveDone;
  winner_t     r_winner;
  logic        r_gameOver;

  logic [8:0]  w_occupied;
  logic [8:0]  w_moverBoard;
  logic        w_isZero;
  logic        w_badSquare;
  logic        w_multiHot;
  logic        w_hitsTaken;
  logic        w_reject;
  logic        w_win;
  logic        w_full;

  assign w_occupied   = r_boardX | r_boardO;
  assign w_isZero     = (r_captured == 16'd0);
  assign w_badSquare  = |r_captured[15:9];
  assign w_multiHot   = ((r_captured & (r_captured - 16'd1)) != 16'd0);
  assign w_hitsTaken  = |(r_captured[8:0] & w_occupied);
  assign w_reject     = w_isZero | w_badSquare | w_multiHot | w_hitsTaken;

  // In EVAL the mover's board already holds the new mark, and turn still
  // names the mover, so the detector only ever looks at that player.
  assign w_moverBoard = r_turn ? r_boardO : r_boardX;
  assign w_full       = (w_occupied == FULL_BOARD);

  win_detector u_winDetector (
    .i_board (w_moverBoard),
    .o_win   (w_win)
  );

  // Single FSM: reset and clear both return to an empty board, clear wins over any pending move.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= PLAY;
      r_captured    <= 16'd0;
      r_boardX      <= 9'd0;
      r_boardO      <= 9'd0;
      r_turn        <= 1'b0;
      r_illegalMove <= 1'b0;
      r_moveDone    <= 1'b0;
      r_winner      <= WIN_NONE;
      r_gameOver    <= 1'b0;
    end else if (bus.clear) begin
      r_state       <= PLAY;
      r_captured    <= 16'd0;
      r_boardX      <= 9'd0;
      r_boardO      <= 9'd0;
      r_turn        <= 1'b0;
      r_illegalMove <= 1'b0;
      r_moveDone    <= 1'b0;
      r_winner      <= WIN_NONE;
      r_gameOver    <= 1'b0;
    end else begin
      r_illegalMove <= 1'b0;
      r_moveDone    <= 1'b0;
      case (r_state)
        PLAY: begin
          if (bus.move_valid) begin
            r_captured <= bus.position_write;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          if (w_reject) begin
            r_illegalMove <= 1'b1;
            r_state       <= PLAY;
          end else begin
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (r_turn) begin
            r_boardO <= r_boardO | r_captured[8:0];
          end else begin
            r_boardX <= r_boardX | r_captured[8:0];
          end
          r_state <= EVAL;
        end
        EVAL: begin
          if (w_win) begin
            r_winner   <= r_turn ? WIN_O : WIN_X;
            r_gameOver <= 1'b1;
            r_state    <= DONE;
          end else if (w_full) begin
            r_winner   <= WIN_DRAW;
            r_gameOver <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_turn     <= ~r_turn;
            r_moveDone <= 1'b1;
            r_state    <= PLAY;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= PLAY;
        end
      endcase
    end
  end

  assign bus.board_x      = r_boardX;
  assign bus.board_o      = r_boardO;
  assign bus.turn         = r_turn;
  assign bus.illegal_move = r_illegalMove;
  assign bus.move_done    = r_moveDone;
  assign bus.winner       = r_winner;
  assign bus.game_over    = r_gameOver;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: legal/illegal moves, win, draw,
// win on the last square, clear priority and reset in the middle of a move.
module tb_move_controller;
  import ttt_pkg::*;

  logic clock = 1'b0;
  logic reset;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] tbExpX;
  logic [8:0] tbExpO;
  logic       tbTurn;

  move_controller_if bus();

  move_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want summary before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
    end
  endtask

  // One-cycle request; returns at the falling edge right after the sampling edge.
  task automatic applyStimulus(input logic [15:0] pos);
    @(negedge clock);
    bus.move_valid     = 1'b1;
    bus.position_write = pos;
    @(negedge clock);
    bus.move_valid     = 1'b0;
    bus.position_write = 16'd0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_boardX"}, {7'd0, bus.board_x}, {7'd0, tbExpX});
    checkOutput({tag, "_boardO"}, {7'd0, bus.board_o}, {7'd0, tbExpO});
    checkOutput({tag, "_turn"}, {15'd0, bus.turn}, {15'd0, tbTurn});
    checkOutput({tag, "_winner"}, {14'd0, bus.winner}, {14'd0, WIN_NONE});
    checkOutput({tag, "_gameOver"}, {15'd0, bus.game_over}, 16'd0);
    checkOutput({tag, "_illegal"}, {15'd0, bus.illegal_move}, 16'd0);
    checkOutput({tag, "_moveDone"}, {15'd0, bus.move_done}, 16'd0);
  endtask

  task automatic clearGame(input string tag);
    @(negedge clock);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    tbExpX = 9'd0;
    tbExpO = 9'd0;
    tbTurn = 1'b0;
    checkIdle(tag);
  endtask

  task automatic illegalMove(input logic [15:0] pos, input string tag);
    applyStimulus(pos);
    @(negedge clock);
    checkOutput({tag, "_pulse"}, {15'd0, bus.illegal_move}, 16'd1);
    @(negedge clock);
    checkOutput({tag, "_pulseEnd"}, {15'd0, bus.illegal_move}, 16'd0);
    checkOutput({tag, "_boardX"}, {7'd0, bus.board_x}, {7'd0, tbExpX});
    checkOutput({tag, "_boardO"}, {7'd0, bus.board_o}, {7'd0, tbExpO});
    checkOutput({tag, "_turn"}, {15'd0, bus.turn}, {15'd0, tbTurn});
  endtask

  // Squares are packed one per nibble, first move in the lowest nibble.
  task automatic playGame(input logic [35:0] squares, input int count,
                          input logic [1:0] finalWinner, input string tag);
    logic [15:0] pos;
    logic        ends;
    for (int i = 0; i < count; i++) begin
      pos  = 16'd1 << (int'(squares[4*i +: 4]) - 1);
      ends = (i == count - 1) && (finalWinner != WIN_NONE);
      if (tbTurn) tbExpO = tbExpO | pos[8:0];
      else        tbExpX = tbExpX | pos[8:0];
      applyStimulus(pos);
      @(negedge clock);
      checkOutput({tag, "_illegal"}, {15'd0, bus.illegal_move}, 16'd0);
      @(negedge clock);
      checkOutput({tag, "_boardX"}, {7'd0, bus.board_x}, {7'd0, tbExpX});
      checkOutput({tag, "_boardO"}, {7'd0, bus.board_o}, {7'd0, tbExpO});
      @(negedge clock);
      checkOutput({tag, "_moveDone"}, {15'd0, bus.move_done}, ends ? 16'd0 : 16'd1);
      if (!ends) tbTurn = ~tbTurn;
      checkOutput({tag, "_turn"}, {15'd0, bus.turn}, {15'd0, tbTurn});
      checkOutput({tag, "_winner"}, {14'd0, bus.winner}, ends ? {14'd0, finalWinner} : 16'd0);
      checkOutput({tag, "_gameOver"}, {15'd0, bus.game_over}, ends ? 16'd1 : 16'd0);
      @(negedge clock);
      checkOutput({tag, "_moveDoneEnd"}, {15'd0, bus.move_done}, 16'd0);
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.move_valid     = 1'b0;
    bus.position_write = 16'd0;
    bus.clear          = 1'b0;
    tbExpX             = 9'd0;
    tbExpO             = 9'd0;
    tbTurn             = 1'b0;
    $display("[TB] start");

    repeat (2) @(negedge clock);
    checkIdle("reset");
    reset = 1'b0;

    playGame(36'h1, 1, WIN_NONE, "legal");

    clearGame("clear1");
    playGame(36'h5, 1, WIN_NONE, "xCenter");
    illegalMove(16'h0010, "occupied");

    illegalMove(16'h0200, "badSquare");
    illegalMove(16'h0000, "zero");
    illegalMove(16'h0003, "twoHot");

    clearGame("clear2");
    playGame(36'h000035241, 5, WIN_X, "win");
    applyStimulus(16'h0100);
    repeat (3) @(negedge clock);
    checkOutput("doneIgnore_boardX", {7'd0, bus.board_x}, 16'h0007);
    checkOutput("doneIgnore_boardO", {7'd0, bus.board_o}, 16'h0018);
    checkOutput("doneIgnore_winner", {14'd0, bus.winner}, {14'd0, WIN_X});
    checkOutput("doneIgnore_gameOver", {15'd0, bus.game_over}, 16'd1);
    checkOutput("doneIgnore_illegal", {15'd0, bus.illegal_move}, 16'd0);

    clearGame("clearDone");
    playGame(36'h5, 1, WIN_NONE, "afterClear");

    clearGame("clear3");
    @(negedge clock);
    bus.clear          = 1'b1;
    bus.move_valid     = 1'b1;
    bus.position_write = 16'h0001;
    @(negedge clock);
    bus.clear          = 1'b0;
    bus.move_valid     = 1'b0;
    bus.position_write = 16'd0;
    repeat (3) @(negedge clock);
    checkIdle("clearWithMove");

    clearGame("clear4");
    playGame(36'h987564231, 9, WIN_DRAW, "draw");

    clearGame("clear5");
    playGame(36'h679582413, 9, WIN_X, "ninthWin");

    clearGame("clear6");
    playGame(36'h1, 1, WIN_NONE, "preReset");
    applyStimulus(16'h0010);
    @(posedge clock);
    #2;
    reset = 1'b1;
    tbExpX = 9'd0;
    tbExpO = 9'd0;
    tbTurn = 1'b0;
    @(negedge clock);
    checkIdle("resetInWrite");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkIdle("resetNoPulse");
    playGame(36'h5, 1, WIN_NONE, "afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
